spi_bus_ctrl: RTL and testbench
===============================

SPI_BUS_CTRL -- requirements
Module: spi_bus_ctrl

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 20, address width; DATA_W, default 16, data width; TIMEOUT, default 255, maximum bus wait cycles.
REQ-002 The block SHALL have one clock, clk, and an asynchronous, active-low reset, reset_n; all state SHALL reset immediately on reset_n low.
REQ-003 Ports (name  direction  width  meaning):
 clk  in  1  system clock
 reset_n  in  1  asynchronous active-low reset
 cs_n  in  1  SPI chip select from data path (active low)
 address_ready  in  1  one-cycle pulse: addr/status valid
 data_ready  in  1  one-cycle pulse: 16-bit data phase finished
 addr  in  ADDR_W  decoded SPI address
 status  in  4  command bits: [2]=write, [1]=burst, [0],[3] ignored
 wdata  in  DATA_W  decoded SPI write data
 rdata  out  DATA_W  read word presented to data path
 bus_req  out  1  bus request
 bus_we  out  1  1=write, 0=read
 bus_addr  out  ADDR_W  bus address
 bus_wdata  out  DATA_W  bus write data
 bus_rdata  in  DATA_W  bus read data, valid with bus_ack
 bus_ack  in  1  one-cycle bus completion pulse
 busy  out  1  high in any state other than IDLE
 err  out  1  sticky timeout flag

Function
REQ-004 The FSM SHALL have states IDLE, RD_REQ, RD_HOLD, WR_WAIT, WR_REQ; all outputs SHALL be registered.
REQ-005 In IDLE, address_ready with cs_n low SHALL latch addr into bus_addr and status[2:1], clear err, and enter WR_WAIT if status[2]=1, else RD_REQ.
REQ-006 address_ready SHALL be ignored outside IDLE or while cs_n is high.
REQ-007 In RD_REQ, bus_req=1 and bus_we=0; on bus_ack, rdata SHALL load bus_rdata in the same edge, and the state SHALL become RD_HOLD.
REQ-008 In RD_HOLD, data_ready with burst=1 SHALL increment bus_addr and return to RD_REQ; with burst=0 it SHALL return to IDLE.
REQ-009 In WR_WAIT, data_ready SHALL latch wdata into bus_wdata and enter WR_REQ.
REQ-010 In WR_REQ, bus_req=1 and bus_we=1; on bus_ack, with burst=1 and cs_n low the block SHALL increment bus_addr and enter WR_WAIT, otherwise it SHALL enter IDLE.
REQ-011 bus_req SHALL deassert on the clock edge that samples bus_ack.
REQ-012 bus_addr, bus_we and bus_wdata SHALL remain stable while bus_req=1.
REQ-013 A ready-to-request latency of exactly one cycle SHALL apply: bus_req SHALL rise on the edge after address_ready (read) or data_ready (write).
REQ-014 bus_addr increment SHALL wrap modulo 2^ADDR_W, so all-ones is followed by 0.
REQ-015 A wait counter SHALL count cycles with bus_req=1 and no bus_ack; at TIMEOUT it SHALL drop bus_req, set err, and go to IDLE. rdata SHALL be unchanged on timeout.
REQ-016 If bus_ack and the timeout occur in the same cycle, bus_ack SHALL win and err SHALL NOT set.
REQ-017 cs_n high in WR_WAIT or RD_HOLD SHALL return the FSM to IDLE on the next edge, with no bus transaction issued.
REQ-018 cs_n high in RD_REQ or WR_REQ SHALL NOT abort the transfer: the handshake SHALL complete (ack or timeout), then the FSM SHALL enter IDLE.
REQ-019 bus_ack received while bus_req=0 SHALL be ignored.
REQ-020 err SHALL stay set until the next accepted address_ready or reset.

Reset
REQ-021 On reset_n low, the FSM SHALL go to IDLE, and bus_req, bus_we, busy and err SHALL be 0; bus_addr, bus_wdata and rdata SHALL be 0; the wait counter and latched status SHALL be 0.
REQ-022 Reset asserted mid-transfer SHALL drop bus_req asynchronously, and no completion SHALL be recorded.

Verification
REQ-023 Single read: address_ready with addr=0x01234 and status=0000, then ack after 3 cycles with bus_rdata=0xBEEF -> one bus_req at 0x01234, bus_we=0, rdata=0xBEEF, IDLE after data_ready.
REQ-024 Single write: status=0100 and addr=0x00010, then data_ready with wdata=0xA5A5 -> bus_req the next cycle with bus_we=1 and bus_wdata=0xA5A5; IDLE after ack.
REQ-025 Burst write wrap: status=0110 and addr=0xFFFFF, with three data_ready pulses -> writes to 0xFFFFF, 0x00000, 0x00001; cs_n high then returns the FSM to IDLE.
REQ-026 Timeout: read with no ack and TIMEOUT=255 -> bus_req drops after 255 cycles, err=1; the next address_ready clears err.
REQ-027 Ack on the timeout cycle -> transfer completes, err=0; cs_n raised during WR_REQ -> the write still completes before IDLE.
REQ-028 Reset asserted during RD_REQ -> bus_req=0 immediately, all outputs at reset values, rdata=0.

Source files
------------

// File: rtl/spi_bus_ctrl.sv
// Bridges decoded SPI address/data phases onto a simple req/ack bus.
// Supports single and burst reads/writes with a bounded wait for bus_ack.
module spi_bus_ctrl #(
  parameter int ADDR_W  = 20,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cs_n,
  input  logic              address_ready,
  input  logic              data_ready,
  input  logic [ADDR_W-1:0] addr,
  input  logic [3:0]        status,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_ack,
  output logic              busy,
  output logic              err
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  // Last counted cycle: bus_req stays high for exactly TIMEOUT cycles without ack.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_HOLD = 3'd2,
    WR_WAIT = 3'd3,
    WR_REQ  = 3'd4
  } state_t;

  state_t            state_reg, state_next;
  logic              bus_req_reg, bus_req_next;
  logic              bus_we_reg, bus_we_next;
  logic              busy_reg, busy_next;
  logic              err_reg, err_next;
  logic [ADDR_W-1:0] bus_addr_reg, bus_addr_next;
  logic [DATA_W-1:0] bus_wdata_reg, bus_wdata_next;
  logic [DATA_W-1:0] rdata_reg, rdata_next;
  logic [CNT_W-1:0]  wait_cnt_reg, wait_cnt_next;
  logic              write_reg, write_next;
  logic              burst_reg, burst_next;

  logic unused_status;
  assign unused_status = status[3] ^ status[0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      bus_req_reg   <= 1'b0;
      bus_we_reg    <= 1'b0;
      busy_reg      <= 1'b0;
      err_reg       <= 1'b0;
      bus_addr_reg  <= '0;
      bus_wdata_reg <= '0;
      rdata_reg     <= '0;
      wait_cnt_reg  <= '0;
      write_reg     <= 1'b0;
      burst_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      bus_req_reg   <= bus_req_next;
      bus_we_reg    <= bus_we_next;
      busy_reg      <= busy_next;
      err_reg       <= err_next;
      bus_addr_reg  <= bus_addr_next;
      bus_wdata_reg <= bus_wdata_next;
      rdata_reg     <= rdata_next;
      wait_cnt_reg  <= wait_cnt_next;
      write_reg     <= write_next;
      burst_reg     <= burst_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    bus_req_next   = bus_req_reg;
    bus_we_next    = bus_we_reg;
    err_next       = err_reg;
    bus_addr_next  = bus_addr_reg;
    bus_wdata_next = bus_wdata_reg;
    rdata_next     = rdata_reg;
    wait_cnt_next  = wait_cnt_reg;
    write_next     = write_reg;
    burst_next     = burst_reg;

    case (state_reg)
      IDLE: begin
        if (address_ready && !cs_n) begin
          bus_addr_next = addr;
          write_next    = status[2];
          burst_next    = status[1];
          err_next      = 1'b0;
          wait_cnt_next = '0;
          if (status[2]) begin
            state_next = WR_WAIT;
          end else begin
            state_next   = RD_REQ;
            bus_req_next = 1'b1;
            bus_we_next  = 1'b0;
          end
        end
      end

      RD_HOLD: begin
        if (cs_n) begin
          state_next = IDLE;
        end else if (data_ready) begin
          if (burst_reg) begin
            bus_addr_next = bus_addr_reg + 1'b1;
            state_next    = RD_REQ;
            bus_req_next  = 1'b1;
            bus_we_next   = 1'b0;
            wait_cnt_next = '0;
          end else begin
            state_next = IDLE;
          end
        end
      end

      WR_WAIT: begin
        if (cs_n) begin
          state_next = IDLE;
        end else if (data_ready) begin
          bus_wdata_next = wdata;
          state_next     = WR_REQ;
          bus_req_next   = 1'b1;
          bus_we_next    = write_reg;
          wait_cnt_next  = '0;
        end
      end

      // Both request states share the handshake; an ack beats a same-cycle timeout.
      RD_REQ, WR_REQ: begin
        if (bus_ack) begin
          bus_req_next = 1'b0;
          if (state_reg == RD_REQ) begin
            rdata_next = bus_rdata;
            state_next = cs_n ? IDLE : RD_HOLD;
          end else if (burst_reg && !cs_n) begin
            bus_addr_next = bus_addr_reg + 1'b1;
            state_next    = WR_WAIT;
          end else begin
            state_next = IDLE;
          end
        end else if (wait_cnt_reg == CNT_LAST) begin
          bus_req_next = 1'b0;
          err_next     = 1'b1;
          state_next   = IDLE;
        end else begin
          wait_cnt_next = wait_cnt_reg + 1'b1;
        end
      end

      default: begin
        state_next   = IDLE;
        bus_req_next = 1'b0;
      end
    endcase

    busy_next = (state_next != IDLE);
  end

  assign rdata     = rdata_reg;
  assign bus_req   = bus_req_reg;
  assign bus_we    = bus_we_reg;
  assign bus_addr  = bus_addr_reg;
  assign bus_wdata = bus_wdata_reg;
  assign busy      = busy_reg;
  assign err       = err_reg;

endmodule

// File: tb/tb_spi_bus_ctrl.sv
// Directed bench for spi_bus_ctrl: vector table of single transfers plus
// hand-written burst, timeout, cs_n and reset corner cases.
module tb_spi_bus_ctrl;
  localparam int AW = 20;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          cs_n = 1'b1;
  logic          address_ready = 1'b0;
  logic          data_ready = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [3:0]    status = '0;
  logic [DW-1:0] wdata = '0;
  logic [DW-1:0] rdata;
  logic          bus_req;
  logic          bus_we;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;
  logic [DW-1:0] bus_rdata = '0;
  logic          bus_ack = 1'b0;
  logic          busy;
  logic          err;

  spi_bus_ctrl #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(255)) dut (
    .clk(clk), .reset_n(reset_n), .cs_n(cs_n),
    .address_ready(address_ready), .data_ready(data_ready),
    .addr(addr), .status(status), .wdata(wdata), .rdata(rdata),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // All driving and sampling happens at the falling edge.
  task automatic do_addr(input logic [AW-1:0] a, input logic [3:0] st);
    addr = a; status = st; cs_n = 1'b0; address_ready = 1'b1;
    @(negedge clk);
    address_ready = 1'b0;
  endtask

  task automatic pulse_ack(input logic [DW-1:0] d);
    bus_rdata = d; bus_ack = 1'b1;
    @(negedge clk);
    bus_ack = 1'b0;
  endtask

  task automatic pulse_dr(input logic [DW-1:0] w);
    wdata = w; data_ready = 1'b1;
    @(negedge clk);
    data_ready = 1'b0;
  endtask

  typedef struct {
    logic          wr;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int            dly;
    logic [DW-1:0] exp_d;
  } vec_t;

  vec_t          vecs[4];
  logic [AW-1:0] wexp[3];
  int            hi_cnt;

  initial begin
    vecs[0] = '{1'b0, 20'h01234, 16'hBEEF, 3, 16'hBEEF};
    vecs[1] = '{1'b1, 20'h00010, 16'hA5A5, 0, 16'hA5A5};
    vecs[2] = '{1'b0, 20'hFFFFF, 16'h0001, 0, 16'h0001};
    vecs[3] = '{1'b1, 20'h00000, 16'hFFFF, 5, 16'hFFFF};
    wexp[0] = 20'hFFFFF; wexp[1] = 20'h00000; wexp[2] = 20'h00001;

    // Reset values
    @(negedge clk);
    check("rst_bus_req", 32'(bus_req), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_bus_addr", 32'(bus_addr), 32'h0);
    check("rst_rdata", 32'(rdata), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    cs_n = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      if (!vecs[i].wr) begin
        do_addr(vecs[i].a, 4'b0000);
        check("rd_req", 32'(bus_req), 32'h1);
        check("rd_we", 32'(bus_we), 32'h0);
        check("rd_addr", 32'(bus_addr), 32'(vecs[i].a));
      end else begin
        do_addr(vecs[i].a, 4'b0100);
        check("wr_wait_req", 32'(bus_req), 32'h0);
        check("wr_wait_busy", 32'(busy), 32'h1);
        pulse_dr(vecs[i].d);
        check("wr_req", 32'(bus_req), 32'h1);
        check("wr_we", 32'(bus_we), 32'h1);
        check("wr_addr", 32'(bus_addr), 32'(vecs[i].a));
        check("wr_wdata", 32'(bus_wdata), 32'(vecs[i].exp_d));
      end
      for (int k = 0; k < vecs[i].dly; k++) begin
        @(negedge clk);
        check("hold_req", 32'(bus_req), 32'h1);
        check("hold_addr", 32'(bus_addr), 32'(vecs[i].a));
      end
      pulse_ack(vecs[i].wr ? 16'h0000 : vecs[i].d);
      check("ack_req", 32'(bus_req), 32'h0);
      if (!vecs[i].wr) begin
        check("rdata", 32'(rdata), 32'(vecs[i].exp_d));
        check("rd_hold_busy", 32'(busy), 32'h1);
        pulse_dr(16'h0000);
      end
      check("idle_busy", 32'(busy), 32'h0);
      $display("[TB] vector %0d %s addr=0x%05h data=0x%04h done", i,
               vecs[i].wr ? "write" : "read", vecs[i].a, vecs[i].d);
    end

    // Stray ack while idle and address_ready with cs_n high are ignored
    pulse_ack(16'hDEAD);
    check("idle_ack_rdata", 32'(rdata), 32'h0001);
    cs_n = 1'b1; address_ready = 1'b1;
    @(negedge clk);
    address_ready = 1'b0;
    check("csn_hi_ignored", 32'(busy), 32'h0);
    $display("[TB] ignored ack/address_ready done");

    // Burst read, then cs_n high in RD_HOLD ends it
    do_addr(20'h00005, 4'b0010);
    pulse_ack(16'h1111);
    check("brd_rdata0", 32'(rdata), 32'h1111);
    pulse_dr(16'h0000);
    check("brd_req1", 32'(bus_req), 32'h1);
    check("brd_addr1", 32'(bus_addr), 32'h00006);
    pulse_ack(16'h2222);
    check("brd_rdata1", 32'(rdata), 32'h2222);
    cs_n = 1'b1;
    @(negedge clk);
    check("brd_csn_idle", 32'(busy), 32'h0);
    check("brd_csn_req", 32'(bus_req), 32'h0);
    cs_n = 1'b0;
    $display("[TB] burst read done");

    // Burst write wrapping past all-ones, cs_n high in WR_WAIT
    do_addr(20'hFFFFF, 4'b0110);
    for (int k = 0; k < 3; k++) begin
      pulse_dr(16'h0100 + 16'(k));
      check("bwr_req", 32'(bus_req), 32'h1);
      check("bwr_addr", 32'(bus_addr), 32'(wexp[k]));
      check("bwr_wdata", 32'(bus_wdata), 32'h0100 + 32'(k));
      pulse_ack(16'h0000);
      check("bwr_ack_req", 32'(bus_req), 32'h0);
      check("bwr_busy", 32'(busy), 32'h1);
    end
    cs_n = 1'b1;
    @(negedge clk);
    check("bwr_csn_idle", 32'(busy), 32'h0);
    cs_n = 1'b0;
    $display("[TB] burst write wrap done");

    // Timeout: bus_req high for exactly 255 cycles, err set, rdata kept
    do_addr(20'h00100, 4'b0000);
    hi_cnt = 0;
    for (int n = 0; n < 300 && bus_req; n++) begin
      hi_cnt++;
      @(negedge clk);
    end
    check("to_cycles", 32'(hi_cnt), 32'd255);
    check("to_err", 32'(err), 32'h1);
    check("to_busy", 32'(busy), 32'h0);
    check("to_rdata", 32'(rdata), 32'h2222);
    do_addr(20'h00101, 4'b0000);
    check("to_err_clear", 32'(err), 32'h0);
    pulse_ack(16'h3333);
    pulse_dr(16'h0000);
    $display("[TB] timeout done, cycles=%0d", hi_cnt);

    // Ack on the timeout cycle wins
    do_addr(20'h00102, 4'b0000);
    repeat (254) @(negedge clk);
    check("ackto_req_still", 32'(bus_req), 32'h1);
    pulse_ack(16'h1357);
    check("ackto_err", 32'(err), 32'h0);
    check("ackto_rdata", 32'(rdata), 32'h1357);
    check("ackto_busy", 32'(busy), 32'h1);
    pulse_dr(16'h0000);
    $display("[TB] ack on timeout cycle done");

    // cs_n raised during WR_REQ: write still completes, then IDLE
    do_addr(20'h00200, 4'b0110);
    pulse_dr(16'h4444);
    cs_n = 1'b1;
    @(negedge clk);
    check("csn_wr_req", 32'(bus_req), 32'h1);
    pulse_ack(16'h0000);
    check("csn_wr_ack_req", 32'(bus_req), 32'h0);
    check("csn_wr_idle", 32'(busy), 32'h0);
    cs_n = 1'b0;
    $display("[TB] cs_n during WR_REQ done");

    // Asynchronous reset during RD_REQ
    do_addr(20'h00300, 4'b0000);
    check("rst_mid_req_pre", 32'(bus_req), 32'h1);
    #2 reset_n = 1'b0;
    #1;
    check("rst_mid_req", 32'(bus_req), 32'h0);
    check("rst_mid_busy", 32'(busy), 32'h0);
    check("rst_mid_rdata", 32'(rdata), 32'h0);
    check("rst_mid_addr", 32'(bus_addr), 32'h0);
    check("rst_mid_err", 32'(err), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    pulse_ack(16'hAAAA);
    check("rst_post_rdata", 32'(rdata), 32'h0);
    $display("[TB] reset mid-transfer done");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
